// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM arbiter states, widths and address layout
package sdram_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACTIVE = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  // Word address layout is {bank, row, col}; positions are shared with the controller
  localparam int SDRAM_COL_W    = 10;
  localparam int SDRAM_ROW_W    = 13;
  localparam int SDRAM_BANK_W   = 2;
  localparam int SDRAM_COL_LSB  = 0;
  localparam int SDRAM_ROW_LSB  = SDRAM_COL_LSB + SDRAM_COL_W;
  localparam int SDRAM_BANK_LSB = SDRAM_ROW_LSB + SDRAM_ROW_W;

  localparam int SDRAM_ADDR_WIDTH = SDRAM_BANK_LSB + SDRAM_BANK_W;
  localparam int SDRAM_DATA_WIDTH = 16;

  // Width of a port index; a single port still needs one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - requester-side and controller-side bus of the SDRAM arbiter
interface sdram_arbiter_if import sdram_pkg::*; #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = SDRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SDRAM_DATA_WIDTH
);

  // Requester side, flattened per port
  logic [NUM_PORTS-1:0]            req_i;
  logic [NUM_PORTS-1:0]            we_i;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_o;
  logic [NUM_PORTS-1:0]            ack_o;
  logic [NUM_PORTS-1:0]            err_o;

  // Controller processor-side interface
  logic [ADDR_WIDTH-1:0]           mem_addr_o;
  logic [DATA_WIDTH-1:0]           mem_data_o;
  logic                            mem_we_o;
  logic                            mem_re_o;
  logic [DATA_WIDTH-1:0]           mem_data_i;
  logic                            mem_ack_i;
  logic                            mem_busy_i;

  // The arbiter itself
  modport slave (
    input  req_i, we_i, addr_i, wdata_i, mem_data_i, mem_ack_i, mem_busy_i,
    output rdata_o, ack_o, err_o, mem_addr_o, mem_data_o, mem_we_o, mem_re_o
  );

  // Requesters plus controller, as seen from outside the arbiter
  modport master (
    output req_i, we_i, addr_i, wdata_i, mem_data_i, mem_ack_i, mem_busy_i,
    input  rdata_o, ack_o, err_o, mem_addr_o, mem_data_o, mem_we_o, mem_re_o
  );

endinterface

// File: rtl/sdram_arbiter_rr_pick.sv
// rtl/sdram_arbiter_rr_pick.sv - combinational round-robin priority picker
module rr_pick import sdram_pkg::*; #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_ptr,
  output logic [IDX_W-1:0]     o_grant,
  output logic                 o_valid
);

  logic [IDX_W-1:0] w_idx;

  // Scan from the port after i_ptr, wrapping, and take the first requester
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_idx = IDX_W'((int'(i_ptr) + k) % NUM_PORTS);
      if (!o_valid && i_req[w_idx]) begin
        o_grant = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin SDRAM port arbiter; optional watchdog under SDRAM_ARB_TIMEOUT_EN
module sdram_arbiter import sdram_pkg::*; #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = SDRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH     = SDRAM_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  sdram_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_num_ports
    $error("sdram_arbiter: NUM_PORTS must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("sdram_arbiter: TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [IDX_W-1:0]      r_ptr;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic [DATA_WIDTH-1:0] r_rdata [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] w_addr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_PORTS];
  logic [IDX_W-1:0]      w_grant;
  logic                  w_grant_valid;
  logic                  w_accept;
  logic                  w_active;
  logic                  w_timeout;

  // Unflatten the per-port buses; r_ptr doubles as the owner of the transaction in flight
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign w_addr[p]  = bus.addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[p] = bus.wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
    assign bus.rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = r_rdata[p];
  end

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .i_req   (bus.req_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_valid (w_grant_valid)
  );

  assign w_active = (r_state == ARB_ACTIVE);

  // Strobes fall in the ack cycle itself so the controller never sees a second request
  assign bus.mem_we_o   = w_active &  r_we & ~bus.mem_ack_i;
  assign bus.mem_re_o   = w_active & ~r_we & ~bus.mem_ack_i;
  assign bus.mem_addr_o = r_mem_addr;
  assign bus.mem_data_o = r_mem_data;

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= ARB_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state: grant when idle and the controller is free, finish on ack or watchdog
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant_valid && !bus.mem_busy_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ARB_ACTIVE;
        end
      end
      ARB_ACTIVE: begin
        if (bus.mem_ack_i || w_timeout) w_state_nxt = ARB_RESP;
      end
      ARB_RESP: w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  // Latch the winner's command; later requester changes are ignored until RESP
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ptr      <= IDX_W'(NUM_PORTS - 1);
      r_we       <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else if (w_accept) begin
      r_ptr      <= w_grant;
      r_we       <= bus.we_i[w_grant];
      r_mem_addr <= w_addr[w_grant];
      r_mem_data <= w_wdata[w_grant];
    end
  end

  // Read data is captured only on a real controller ack for a read
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int p = 0; p < NUM_PORTS; p++) r_rdata[p] <= '0;
    end else if (w_active && bus.mem_ack_i && !r_we) begin
      r_rdata[r_ptr] <= bus.mem_data_i;
    end
  end

  // Completion pulse to the owner during the single RESP cycle
  always_comb begin
    bus.ack_o = '0;
    if (r_state == ARB_RESP) bus.ack_o[r_ptr] = 1'b1;
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        r_err;

  // Give up on the controller after TIMEOUT_CYCLES active cycles; a same-cycle ack wins
  assign w_timeout = w_active && !bus.mem_ack_i && (r_wdog == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog: cleared on grant, counts every ACTIVE cycle
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)       r_wdog <= '0;
    else if (w_accept) r_wdog <= '0;
    else if (w_active) r_wdog <= r_wdog + 16'd1;
  end

  // Remember whether ACTIVE ended by timeout so RESP can flag it
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)       r_err <= 1'b0;
    else if (w_active) r_err <= w_timeout;
  end

  // Error pulse coincides with the owner's ack
  always_comb begin
    bus.err_o = '0;
    if (r_state == ARB_RESP && r_err) bus.err_o[r_ptr] = 1'b1;
  end
`else
  assign w_timeout = 1'b0;
  assign bus.err_o = '0;
`endif

  a_ack_onehot: assert property (@(posedge sys_clk) disable iff (sys_rst) $onehot0(bus.ack_o));
  a_strobe_excl: assert property (@(posedge sys_clk) disable iff (sys_rst) !(bus.mem_we_o && bus.mem_re_o));

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed vector bench for sdram_arbiter
module tb_sdram_arbiter;

  localparam int NP = 2;
  localparam int AW = 25;
  localparam int DW = 16;
`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sdram_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    int            delay;
    logic [DW-1:0] rd;
    int            exp_port;
    logic [AW-1:0] exp_addr;
    logic          exp_we;
    logic [DW-1:0] exp_d;
    logic [2*DW-1:0] exp_rdata;
  } vec_t;

  typedef struct {
    int            port;
    int            strobes;
    logic          late;
    logic          stable;
    logic [AW-1:0] a;
    logic          we;
    logic [DW-1:0] d;
    logic          err;
    int            extra;
  } res_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rd_port(input int p);
    return bus.rdata_o[p*DW +: DW];
  endfunction

  task automatic set_port(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we_i[p]            = we;
    bus.addr_i[p*AW +: AW] = a;
    bus.wdata_i[p*DW +: DW] = d;
  endtask

  // Controller stub: waits for a strobe, acks after 'delay' strobe cycles, reports the RESP cycle
  task automatic serve(input string tag, input int delay, input logic [DW-1:0] rd, input bit drop,
                       output res_t r);
    int n;
    r = '{port: -1, strobes: 0, late: 1'b0, stable: 1'b1, a: '0, we: 1'b0, d: '0, err: 1'b0, extra: 0};
    n = 0;
    while (!(bus.mem_we_o || bus.mem_re_o) && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_strobe_wait"}, (n < 50), 1'b1);
    if (n >= 50) return;
    r.a  = bus.mem_addr_o;
    r.we = bus.mem_we_o;
    r.d  = bus.mem_data_o;
    if (drop) begin
      bus.addr_i  = ~bus.addr_i;
      bus.wdata_i = ~bus.wdata_i;
      bus.we_i    = ~bus.we_i;
    end
    for (int i = 0; i < delay; i++) begin
      if (bus.mem_we_o || bus.mem_re_o) r.strobes++;
      if (bus.mem_addr_o !== r.a || bus.mem_data_o !== r.d) r.stable = 1'b0;
      tick();
    end
    bus.mem_data_i = rd;
    bus.mem_ack_i  = 1'b1;
    #1;
    r.late = bus.mem_we_o | bus.mem_re_o;
    tick();
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    for (int p = 0; p < NP; p++) if (bus.ack_o[p]) r.port = p;
    r.err = |bus.err_o;
    if (drop) begin
      bus.req_i = '0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (|bus.ack_o) r.extra++;
        if (bus.mem_we_o || bus.mem_re_o) r.extra++;
      end
    end
  endtask

  vec_t vt[7];
  res_t r;
  int   n;
  int   cnt;

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2'b01, 2'b01, 25'h0001234, 25'h0, 16'hBEEF, 16'h0, 6, 16'h0,
              0, 25'h0001234, 1'b1, 16'hBEEF, 32'h0000_1111};
    vt[1] = '{2'b10, 2'b00, 25'h0, 25'h1FFFFFF, 16'h0, 16'h7777, 3, 16'hA5A5,
              1, 25'h1FFFFFF, 1'b0, 16'h7777, 32'hA5A5_1111};
    vt[2] = '{2'b01, 2'b01, 25'h0000002, 25'h0, 16'h1234, 16'h0, 1, 16'hDEAD,
              0, 25'h0000002, 1'b1, 16'h1234, 32'hA5A5_1111};
    vt[3] = '{2'b11, 2'b00, 25'h0AAAAAA, 25'h1555555, 16'h0101, 16'h0202, 2, 16'h5A5A,
              1, 25'h1555555, 1'b0, 16'h0202, 32'h5A5A_1111};
    vt[4] = '{2'b11, 2'b11, 25'h0800400, 25'h0000003, 16'hCAFE, 16'hF00D, 4, 16'h0,
              0, 25'h0800400, 1'b1, 16'hCAFE, 32'h5A5A_1111};
    vt[5] = '{2'b11, 2'b01, 25'h0000010, 25'h0000000, 16'h3333, 16'h4444, 0, 16'hFFFF,
              1, 25'h0000000, 1'b0, 16'h4444, 32'hFFFF_1111};
    vt[6] = '{2'b01, 2'b00, 25'h1FFFFFF, 25'h0, 16'h5555, 16'h0, 1, 16'h0000,
              0, 25'h1FFFFFF, 1'b0, 16'h5555, 32'hFFFF_0000};

    bus.req_i = '0; bus.we_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
    bus.mem_data_i = '0; bus.mem_ack_i = 1'b0; bus.mem_busy_i = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_ack", bus.ack_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_rdata", bus.rdata_o, 0);
    chk("rst_mem_addr", bus.mem_addr_o, 0);
    chk("rst_mem_data", bus.mem_data_o, 0);
    chk("rst_we", bus.mem_we_o, 0);
    chk("rst_re", bus.mem_re_o, 0);
    rst = 1'b0;

    // Controller busy holds off a pending read
    set_port(0, 1'b0, 25'h0000100, 16'h0);
    bus.req_i = 2'b01;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.mem_we_o || bus.mem_re_o) cnt++;
    end
    chk("busy_no_strobe", cnt, 0);
    bus.mem_busy_i = 1'b0;
    tick();
    chk("busy_release_re", bus.mem_re_o, 1'b1);
    chk("busy_release_we", bus.mem_we_o, 1'b0);
    chk("busy_release_addr", bus.mem_addr_o, 25'h0000100);
    serve("busy", 2, 16'h1111, 1'b1, r);
    chk("busy_port", r.port, 0);
    chk("busy_rdata0", rd_port(0), 16'h1111);

    // Table-driven single transactions
    for (int i = 0; i < 7; i++) begin
      set_port(0, vt[i].we[0], vt[i].a0, vt[i].d0);
      set_port(1, vt[i].we[1], vt[i].a1, vt[i].d1);
      bus.req_i = vt[i].req;
      serve($sformatf("v%0d", i), vt[i].delay, vt[i].rd, 1'b1, r);
      chk($sformatf("v%0d_port", i), r.port, vt[i].exp_port);
      chk($sformatf("v%0d_addr", i), r.a, vt[i].exp_addr);
      chk($sformatf("v%0d_we", i), r.we, vt[i].exp_we);
      chk($sformatf("v%0d_mdata", i), r.d, vt[i].exp_d);
      chk($sformatf("v%0d_strobes", i), r.strobes, vt[i].delay);
      chk($sformatf("v%0d_strobe_in_ack", i), r.late, 1'b0);
      chk($sformatf("v%0d_stable", i), r.stable, 1'b1);
      chk($sformatf("v%0d_err", i), r.err, 1'b0);
      chk($sformatf("v%0d_extra", i), r.extra, 0);
      chk($sformatf("v%0d_rdata", i), bus.rdata_o, vt[i].exp_rdata);
    end

    // Reset in the middle of an active write
    set_port(0, 1'b1, 25'h0000555, 16'h9999);
    bus.req_i = 2'b01;
    n = 0;
    while (!bus.mem_we_o && n < 50) begin
      tick();
      n++;
    end
    chk("midrst_strobe_seen", bus.mem_we_o, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_we", bus.mem_we_o, 1'b0);
    chk("midrst_re", bus.mem_re_o, 1'b0);
    chk("midrst_addr", bus.mem_addr_o, 0);
    chk("midrst_rdata", bus.rdata_o, 0);
    bus.req_i = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    bus.mem_data_i = 16'hBAD0;
    bus.mem_ack_i  = 1'b1;
    tick();
    bus.mem_ack_i  = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (|bus.ack_o || bus.mem_we_o || bus.mem_re_o) cnt++;
      tick();
    end
    chk("stray_ack_ignored", cnt, 0);
    chk("stray_rdata", bus.rdata_o, 0);

    // Both ports requesting continuously: strict rotation starting at port 0
    set_port(0, 1'b0, 25'h0000020, 16'h0);
    set_port(1, 1'b0, 25'h0000040, 16'h0);
    bus.req_i = 2'b11;
    for (int i = 0; i < 6; i++) begin
      serve($sformatf("rot%0d", i), 1, 16'h1000 + 16'(i), 1'b0, r);
      chk($sformatf("rot%0d_grant", i), r.port, i % 2);
      chk($sformatf("rot%0d_addr", i), r.a, (i % 2 == 0) ? 25'h0000020 : 25'h0000040);
      chk($sformatf("rot%0d_rdata", i), rd_port(i % 2), 16'h1000 + 16'(i));
    end
    bus.req_i = '0;
    repeat (3) tick();

`ifdef SDRAM_ARB_TIMEOUT_EN
    // Controller never acks: watchdog completes the transaction with an error
    set_port(0, 1'b0, 25'h0000777, 16'h0);
    bus.req_i = 2'b01;
    n = 0;
    while (!bus.mem_re_o && n < 50) begin
      tick();
      n++;
    end
    chk("to_strobe_seen", bus.mem_re_o, 1'b1);
    cnt = 0;
    n = 0;
    while (bus.ack_o == '0 && n < 100) begin
      if (bus.mem_re_o) cnt++;
      tick();
      n++;
    end
    chk("to_strobe_cycles", cnt, TO);
    chk("to_ack", bus.ack_o, 2'b01);
    chk("to_err", bus.err_o, 2'b01);
    chk("to_rdata_kept", rd_port(0), 16'h1004);
    bus.req_i = '0;
    tick();
    chk("to_ack_single", bus.ack_o, 2'b00);
    set_port(0, 1'b1, 25'h0000888, 16'h4321);
    bus.req_i = 2'b01;
    serve("to_next", 2, 16'h0, 1'b1, r);
    chk("to_next_port", r.port, 0);
    chk("to_next_err", r.err, 1'b0);
    chk("to_next_addr", r.a, 25'h0000888);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Round-robin arbiter sharing the single-port SDRAM controller between NUM_PORTS requesters (e.g. CPU data, CPU fetch, video/DMA).
- Per port: latches one request, presents it on the controller's processor-side interface (addr/data/we/re), waits for the controller ack, returns read data and an ack pulse to the owning requester.
- Sits between the requesters and the SDRAM controller; one transaction in flight at a time.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- ADDR_WIDTH, 25, word address width ({bank[24:23], row[22:10], col[9:0]}).
- DATA_WIDTH, 16, SDRAM word width.
- TIMEOUT_CYCLES, 1024, watchdog limit in sys_clk cycles (used only with SDRAM_ARB_TIMEOUT_EN).

Ports:
- sys_clk  in  1  single clock, same as the SDRAM controller.
- sys_rst  in  1  asynchronous, active-high reset.
- req_i  in  NUM_PORTS  per-port request level; held until that port's ack_o.
- we_i  in  NUM_PORTS  per-port 1=write, 0=read; valid while req_i is high.
- addr_i  in  NUM_PORTS*ADDR_WIDTH  flattened addresses; port p = [p*ADDR_WIDTH +: ADDR_WIDTH].
- wdata_i  in  NUM_PORTS*DATA_WIDTH  flattened write data.
- rdata_o  out  NUM_PORTS*DATA_WIDTH  flattened read data; valid on ack, held until that port's next read completes.
- ack_o  out  NUM_PORTS  one-cycle completion pulse per port.
- err_o  out  NUM_PORTS  one-cycle timeout pulse, coincident with ack_o (tied 0 without macro).
- mem_addr_o  out  ADDR_WIDTH  address to controller.
- mem_data_o  out  DATA_WIDTH  write data to controller.
- mem_we_o  out  1  write strobe to controller.
- mem_re_o  out  1  read strobe to controller.
- mem_data_i  in  DATA_WIDTH  read data from controller.
- mem_ack_i  in  1  controller completion pulse.
- mem_busy_i  in  1  controller busy (init/refresh/transaction).

Behaviour:
- Reset (async, immediate):
  - state=IDLE; rr pointer=NUM_PORTS-1.
  - All outputs 0: ack_o, err_o, rdata_o, mem_addr_o, mem_data_o, mem_we_o, mem_re_o.
  - Reset mid-transaction: strobes drop immediately. A later stray mem_ack_i is ignored in IDLE.
- FSM IDLE:
  - If (|req_i) && !mem_busy_i: grant = first requesting port searching from pointer+1 modulo NUM_PORTS.
  - Latch the granted port's addr/we/wdata into mem_addr_o/mem_data_o and an internal we bit; pointer<=grant; go ACTIVE.
  - If mem_busy_i is high, or no request is pending: stay in IDLE.
- FSM ACTIVE:
  - mem_we_o = ACTIVE & we_latched & !mem_ack_i; mem_re_o = ACTIVE & !we_latched & !mem_ack_i.
  - The !mem_ack_i gating is combinational and mandatory: the controller re-samples its strobes in the same cycle it acks, so gating prevents a duplicate transaction.
  - mem_addr_o and mem_data_o are held stable throughout ACTIVE.
  - On mem_ack_i: if read, rdata_o[grant]<=mem_data_i; go RESP.
- FSM RESP: ack_o[grant]=1 for exactly this cycle; req_i is not sampled; go IDLE.
- Latency: request accepted in IDLE → strobe visible the next cycle → ack_o one cycle after mem_ack_i. Minimum arbitration overhead is 2 cycles plus the controller's own latency.
- Requester contract:
  - Deassert req_i on the edge after seeing ack_o, or keep it high to issue a new request.
  - Changes to req/we/addr/wdata after grant are ignored until RESP.
- Fairness: a port granted last has the lowest priority next. Continuous requests on all ports produce strict rotation 0,1,..,N-1,0.
- mem_ack_i outside ACTIVE is ignored. Only one ack_o bit may be high in any cycle.
- Assertions: $onehot0(ack_o); never (mem_we_o & mem_re_o).

Optional Feature:
- SDRAM_ARB_TIMEOUT_EN defined:
  - A 16-bit watchdog clears on entry to ACTIVE and increments each ACTIVE cycle.
  - On reaching TIMEOUT_CYCLES without mem_ack_i: strobes drop; go RESP with ack_o[grant]=1 and err_o[grant]=1; rdata_o is left unchanged.
- Undefined: no counter; err_o tied 0; ACTIVE waits indefinitely.

Decomposition:
- Shared package sdram_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_ACTIVE, ARB_RESP}.
  - SDRAM_ADDR_WIDTH=25, SDRAM_DATA_WIDTH=16 constants.
  - Address field slices (bank/row/col bit positions) shared with the controller.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, pointer. Outputs: grant index, valid.
  - Reusable by later multi-master blocks.

Test Plan:
- Post-reset idle: mem_busy_i=1 for 20 cycles with req_i=2'b01 → no strobe. mem_busy_i drops → mem_re_o next cycle with mem_addr_o = port0 addr.
- Port0 write 0x0001234 ← 0xBEEF, stub acks after 6 cycles → mem_we_o high exactly 6 cycles and low in the ack cycle; ack_o[0] pulses once, one cycle later; no second transaction.
- Port1 read 0x1FFFFFF, stub returns 0xA5A5 → rdata_o[1]=0xA5A5 on ack_o[1] and held through a following port0 write.
- req_i=2'b11 held continuously, 6 transactions → grant order 0,1,0,1,0,1.
- Reset asserted mid-ACTIVE → strobes low immediately; stub's later ack produces no ack_o; next request after reset serviced normally.
- With SDRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, stub never acks → ack_o[0]&err_o[0] on cycle ~17 after strobe; next request granted normally.
